// File: rtl/eu_operand_collector.sv
// Operand collector between the per-EU instruction queue and the ALU.
// Ports: IQueue handshake (instr_*), RF read (rf_*), forward snoop
// (fwd_*), ALU issue handshake (issue_*), flush_i, busy_o, wait_cycles_o.
module eu_operand_collector #(
    parameter int  DATA_WIDTH        = 16,
    parameter int  TAG_WIDTH         = 6,
    parameter int  NUM_FWD_PORTS     = 2,
    parameter int  WAIT_CTR_WIDTH    = 8,
    parameter type type_iqueue_entry = logic [15:0]
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  type_iqueue_entry                          instr_i,
    input  logic                                      instr_valid_i,
    output logic                                      instr_ready_o,
    input  logic [TAG_WIDTH-1:0]                      src_a_tag_i,
    input  logic [TAG_WIDTH-1:0]                      src_b_tag_i,
    input  logic                                      src_b_imm_i,
    input  logic [DATA_WIDTH-1:0]                     imm_i,
    output logic                                      rf_rd_en_o,
    output logic [TAG_WIDTH-1:0]                      rf_rd_tag_a_o,
    output logic [TAG_WIDTH-1:0]                      rf_rd_tag_b_o,
    input  logic [DATA_WIDTH-1:0]                     rf_rd_data_a_i,
    input  logic [DATA_WIDTH-1:0]                     rf_rd_data_b_i,
    input  logic                                      rf_rd_hit_a_i,
    input  logic                                      rf_rd_hit_b_i,
    input  logic [NUM_FWD_PORTS-1:0]                  fwd_valid_i,
    input  logic [NUM_FWD_PORTS-1:0][TAG_WIDTH-1:0]   fwd_tag_i,
    input  logic [NUM_FWD_PORTS-1:0][DATA_WIDTH-1:0]  fwd_data_i,
    output type_iqueue_entry                          issue_instr_o,
    output logic [DATA_WIDTH-1:0]                     issue_op_a_o,
    output logic [DATA_WIDTH-1:0]                     issue_op_b_o,
    output logic                                      issue_valid_o,
    input  logic                                      issue_ready_i,
    input  logic                                      flush_i,
    output logic                                      busy_o,
    output logic [WAIT_CTR_WIDTH-1:0]                 wait_cycles_o
);

    typedef enum logic [1:0] {IDLE, READ, COLLECT, ISSUE} state_e;

    state_e                    state_q, state_d;
    type_iqueue_entry          instr_q, instr_d;
    logic [TAG_WIDTH-1:0]      tag_a_q, tag_a_d;
    logic [TAG_WIDTH-1:0]      tag_b_q, tag_b_d;
    logic                      b_imm_q, b_imm_d;
    logic [DATA_WIDTH-1:0]     op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]     op_b_q, op_b_d;
    logic                      rdy_a_q, rdy_a_d;
    logic                      rdy_b_q, rdy_b_d;
    logic [WAIT_CTR_WIDTH-1:0] wait_q, wait_d;

    logic                      fwd_hit_a, fwd_hit_b;
    logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;

    // Scan from the highest port down so the lowest matching index wins.
    always_comb begin
        fwd_hit_a = 1'b0;
        fwd_hit_b = 1'b0;
        fwd_a     = '0;
        fwd_b     = '0;
        for (int k = NUM_FWD_PORTS - 1; k >= 0; k--) begin
            if (fwd_valid_i[k] && fwd_tag_i[k] == tag_a_q) begin
                fwd_hit_a = 1'b1;
                fwd_a     = fwd_data_i[k];
            end
            if (fwd_valid_i[k] && fwd_tag_i[k] == tag_b_q) begin
                fwd_hit_b = 1'b1;
                fwd_b     = fwd_data_i[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        tag_a_d = tag_a_q;
        tag_b_d = tag_b_q;
        b_imm_d = b_imm_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        rdy_a_d = rdy_a_q;
        rdy_b_d = rdy_b_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid_i && !flush_i) begin
                    instr_d = instr_i;
                    tag_a_d = src_a_tag_i;
                    tag_b_d = src_b_tag_i;
                    b_imm_d = src_b_imm_i;
                    rdy_a_d = 1'b0;
                    rdy_b_d = src_b_imm_i;
                    wait_d  = '0;
                    if (src_b_imm_i) begin
                        op_b_d = imm_i;
                    end
                    state_d = READ;
                end
            end
            READ: begin
                // RF hit beats a same-cycle forward of the same tag.
                if (!rdy_a_q) begin
                    if (rf_rd_hit_a_i) begin
                        op_a_d  = rf_rd_data_a_i;
                        rdy_a_d = 1'b1;
                    end else if (fwd_hit_a) begin
                        op_a_d  = fwd_a;
                        rdy_a_d = 1'b1;
                    end
                end
                if (!rdy_b_q && !b_imm_q) begin
                    if (rf_rd_hit_b_i) begin
                        op_b_d  = rf_rd_data_b_i;
                        rdy_b_d = 1'b1;
                    end else if (fwd_hit_b) begin
                        op_b_d  = fwd_b;
                        rdy_b_d = 1'b1;
                    end
                end
                state_d = (rdy_a_d && rdy_b_d) ? ISSUE : COLLECT;
            end
            COLLECT: begin
                if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
                if (!rdy_a_q && fwd_hit_a) begin
                    op_a_d  = fwd_a;
                    rdy_a_d = 1'b1;
                end
                if (!rdy_b_q && !b_imm_q && fwd_hit_b) begin
                    op_b_d  = fwd_b;
                    rdy_b_d = 1'b1;
                end
                if (rdy_a_d && rdy_b_d) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            rdy_a_d = 1'b0;
            rdy_b_d = 1'b0;
            wait_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            tag_a_q <= '0;
            tag_b_q <= '0;
            b_imm_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rdy_a_q <= 1'b0;
            rdy_b_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            tag_a_q <= tag_a_d;
            tag_b_q <= tag_b_d;
            b_imm_q <= b_imm_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rdy_a_q <= rdy_a_d;
            rdy_b_q <= rdy_b_d;
            wait_q  <= wait_d;
        end
    end

    // Gated by reset so the accept strobe is low while reset is held.
    assign instr_ready_o = (state_q == IDLE) && !flush_i && !reset;
    assign rf_rd_en_o    = (state_q == READ);
    assign rf_rd_tag_a_o = tag_a_q;
    assign rf_rd_tag_b_o = tag_b_q;
    assign issue_instr_o = instr_q;
    assign issue_op_a_o  = op_a_q;
    assign issue_op_b_o  = op_b_q;
    assign issue_valid_o = (state_q == ISSUE);
    assign busy_o        = (state_q != IDLE);
    assign wait_cycles_o = wait_q;

endmodule

// File: tb/tb_eu_operand_collector.sv
// Self-checking bench for eu_operand_collector: vector table of single
// transactions plus directed stall, flush/saturation and reset sequences.
module tb_eu_operand_collector;

    logic                  clk;
    logic                  reset;
    logic [15:0]           instr_i;
    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [5:0]            src_a_tag_i;
    logic [5:0]            src_b_tag_i;
    logic                  src_b_imm_i;
    logic [15:0]           imm_i;
    logic                  rf_rd_en_o;
    logic [5:0]            rf_rd_tag_a_o;
    logic [5:0]            rf_rd_tag_b_o;
    logic [15:0]           rf_rd_data_a_i;
    logic [15:0]           rf_rd_data_b_i;
    logic                  rf_rd_hit_a_i;
    logic                  rf_rd_hit_b_i;
    logic [1:0]            fwd_valid_i;
    logic [1:0][5:0]       fwd_tag_i;
    logic [1:0][15:0]      fwd_data_i;
    logic [15:0]           issue_instr_o;
    logic [15:0]           issue_op_a_o;
    logic [15:0]           issue_op_b_o;
    logic                  issue_valid_o;
    logic                  issue_ready_i;
    logic                  flush_i;
    logic                  busy_o;
    logic [7:0]            wait_cycles_o;

    int errors = 0;
    int checks = 0;

    eu_operand_collector dut (
        .clk           (clk),
        .reset         (reset),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .src_a_tag_i   (src_a_tag_i),
        .src_b_tag_i   (src_b_tag_i),
        .src_b_imm_i   (src_b_imm_i),
        .imm_i         (imm_i),
        .rf_rd_en_o    (rf_rd_en_o),
        .rf_rd_tag_a_o (rf_rd_tag_a_o),
        .rf_rd_tag_b_o (rf_rd_tag_b_o),
        .rf_rd_data_a_i(rf_rd_data_a_i),
        .rf_rd_data_b_i(rf_rd_data_b_i),
        .rf_rd_hit_a_i (rf_rd_hit_a_i),
        .rf_rd_hit_b_i (rf_rd_hit_b_i),
        .fwd_valid_i   (fwd_valid_i),
        .fwd_tag_i     (fwd_tag_i),
        .fwd_data_i    (fwd_data_i),
        .issue_instr_o (issue_instr_o),
        .issue_op_a_o  (issue_op_a_o),
        .issue_op_b_o  (issue_op_b_o),
        .issue_valid_o (issue_valid_o),
        .issue_ready_i (issue_ready_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .wait_cycles_o (wait_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      instr;
        logic [5:0]       ta;
        logic [5:0]       tb;
        logic             bimm;
        logic [15:0]      imm;
        logic             ha;
        logic             hb;
        logic [15:0]      da;
        logic [15:0]      db;
        int               fcyc;
        logic [1:0]       fv;
        logic [1:0][5:0]  ft;
        logic [1:0][15:0] fd;
        int               ecyc;
        logic [15:0]      ea;
        logic [15:0]      eb;
        logic [7:0]       ew;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; cycle 0 is the accept cycle.
    task automatic run_vec(input vec_t v, input int idx);
        bit seen;
        seen           = 1'b0;
        instr_i        = v.instr;
        src_a_tag_i    = v.ta;
        src_b_tag_i    = v.tb;
        src_b_imm_i    = v.bimm;
        imm_i          = v.imm;
        rf_rd_hit_a_i  = v.ha;
        rf_rd_hit_b_i  = v.hb;
        rf_rd_data_a_i = v.da;
        rf_rd_data_b_i = v.db;
        for (int c = 0; c < 16 && !seen; c++) begin
            instr_valid_i = (c == 0);
            fwd_valid_i   = (c == v.fcyc) ? v.fv : 2'b00;
            fwd_tag_i     = v.ft;
            fwd_data_i    = v.fd;
            @(negedge clk);
            if (c == 0) chk($sformatf("v%0d ready", idx),
                            instr_ready_o, 1);
            if (c == 1) chk($sformatf("v%0d rf_en", idx),
                            rf_rd_en_o, 1);
            if (issue_valid_o) begin
                seen = 1'b1;
                chk($sformatf("v%0d cycle", idx), c, v.ecyc);
                chk($sformatf("v%0d op_a", idx), issue_op_a_o, v.ea);
                chk($sformatf("v%0d op_b", idx), issue_op_b_o, v.eb);
                chk($sformatf("v%0d wait", idx), wait_cycles_o, v.ew);
                chk($sformatf("v%0d instr", idx), issue_instr_o,
                    v.instr);
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL v%0d timeout: no issue_valid within 16", idx);
        end
        instr_valid_i = 1'b0;
        fwd_valid_i   = 2'b00;
        @(negedge clk);
        chk($sformatf("v%0d idle_after", idx), busy_o, 0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] snap_a, snap_b, snap_i;

    initial begin
        vecs[0] = '{16'hA001, 6'd1, 6'd2, 1'b0, 16'h0, 1'b1, 1'b1,
                    16'h1234, 16'h00FF, 15, 2'b00, {6'd0, 6'd0},
                    {16'h0, 16'h0}, 2, 16'h1234, 16'h00FF, 8'd0};
        vecs[1] = '{16'hA002, 6'd5, 6'd3, 1'b0, 16'h0, 1'b0, 1'b1,
                    16'h0, 16'h0042, 4, 2'b10, {6'd5, 6'd0},
                    {16'hBEEF, 16'h0}, 5, 16'hBEEF, 16'h0042, 8'd3};
        vecs[2] = '{16'hA003, 6'd4, 6'd6, 1'b1, 16'h0007, 1'b1, 1'b0,
                    16'hAAAA, 16'hDEAD, 15, 2'b00, {6'd0, 6'd0},
                    {16'h0, 16'h0}, 2, 16'hAAAA, 16'h0007, 8'd0};
        vecs[3] = '{16'hA004, 6'd5, 6'd2, 1'b0, 16'h0, 1'b0, 1'b1,
                    16'h0, 16'h0B0B, 1, 2'b11, {6'd5, 6'd5},
                    {16'h2222, 16'h1111}, 2, 16'h1111, 16'h0B0B, 8'd0};
        vecs[4] = '{16'hA005, 6'd9, 6'd10, 1'b0, 16'h0, 1'b0, 1'b0,
                    16'h0, 16'h0, 3, 2'b11, {6'd9, 6'd10},
                    {16'h6666, 16'h5555}, 4, 16'h6666, 16'h5555, 8'd2};
        vecs[5] = '{16'hA006, 6'd3, 6'd2, 1'b0, 16'h0, 1'b1, 1'b1,
                    16'h0101, 16'h0202, 1, 2'b01, {6'd0, 6'd3},
                    {16'h0, 16'h9999}, 2, 16'h0101, 16'h0202, 8'd0};
        vecs[6] = '{16'hA007, 6'd7, 6'd7, 1'b1, 16'h0033, 1'b0, 1'b1,
                    16'h0, 16'hFFFF, 2, 2'b01, {6'd0, 6'd7},
                    {16'h0, 16'h7777}, 3, 16'h7777, 16'h0033, 8'd1};

        reset          = 1'b1;
        instr_i        = '0;
        instr_valid_i  = 1'b0;
        src_a_tag_i    = '0;
        src_b_tag_i    = '0;
        src_b_imm_i    = 1'b0;
        imm_i          = '0;
        rf_rd_data_a_i = '0;
        rf_rd_data_b_i = '0;
        rf_rd_hit_a_i  = 1'b0;
        rf_rd_hit_b_i  = 1'b0;
        fwd_valid_i    = '0;
        fwd_tag_i      = '0;
        fwd_data_i     = '0;
        issue_ready_i  = 1'b1;
        flush_i        = 1'b0;

        #1;
        chk("rst ready", instr_ready_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst valid", issue_valid_o, 0);
        chk("rst rf_en", rf_rd_en_o, 0);
        chk("rst wait", wait_cycles_o, 0);
        chk("rst op_a", issue_op_a_o, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("post rst ready", instr_ready_o, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // ISSUE stall: outputs hold while issue_ready_i is low.
        issue_ready_i  = 1'b0;
        instr_i        = 16'hB001;
        src_a_tag_i    = 6'd1;
        src_b_tag_i    = 6'd2;
        src_b_imm_i    = 1'b0;
        rf_rd_hit_a_i  = 1'b1;
        rf_rd_hit_b_i  = 1'b1;
        rf_rd_data_a_i = 16'h1234;
        rf_rd_data_b_i = 16'h00FF;
        instr_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        instr_valid_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall valid c2", issue_valid_o, 1);
        snap_a = 16'h1234;
        snap_b = 16'h00FF;
        snap_i = 16'hB001;
        for (int c = 3; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) issue_ready_i = 1'b1;
            @(negedge clk);
            chk($sformatf("stall valid c%0d", c), issue_valid_o, 1);
            chk($sformatf("stall op_a c%0d", c), issue_op_a_o, snap_a);
            chk($sformatf("stall op_b c%0d", c), issue_op_b_o, snap_b);
            chk($sformatf("stall instr c%0d", c), issue_instr_o, snap_i);
            chk($sformatf("stall ready c%0d", c), instr_ready_o, 0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall done busy", busy_o, 0);
        chk("stall done ready", instr_ready_o, 1);
        @(posedge clk);
        #1;

        // Wait counter saturation, then flush out of COLLECT.
        instr_i       = 16'hC001;
        src_a_tag_i   = 6'd5;
        src_b_tag_i   = 6'd2;
        rf_rd_hit_a_i = 1'b0;
        rf_rd_hit_b_i = 1'b1;
        instr_valid_i = 1'b1;
        @(posedge clk);
        #1;
        instr_valid_i = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat wait", wait_cycles_o, 8'hFF);
        chk("sat busy", busy_o, 1);
        chk("sat valid", issue_valid_o, 0);
        @(posedge clk);
        #1;
        flush_i       = 1'b1;
        instr_valid_i = 1'b1;
        @(negedge clk);
        chk("flush ready", instr_ready_o, 0);
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("flush busy", busy_o, 0);
        chk("flush wait", wait_cycles_o, 0);
        chk("flush ready after", instr_ready_o, 1);
        @(posedge clk);
        #1;
        fwd_valid_i = 2'b01;
        fwd_tag_i   = {6'd0, 6'd5};
        fwd_data_i  = {16'h0, 16'hBEEF};
        @(negedge clk);
        @(posedge clk);
        #1;
        fwd_valid_i = 2'b00;
        @(negedge clk);
        chk("stale fwd busy", busy_o, 0);
        chk("stale fwd valid", issue_valid_o, 0);
        @(posedge clk);
        #1;
        run_vec(vecs[0], 7);

        // Asynchronous reset while waiting in ISSUE.
        issue_ready_i  = 1'b0;
        instr_i        = 16'hD001;
        src_a_tag_i    = 6'd1;
        src_b_tag_i    = 6'd2;
        rf_rd_hit_a_i  = 1'b1;
        rf_rd_hit_b_i  = 1'b1;
        instr_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        instr_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("pre rst valid", issue_valid_o, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid rst valid", issue_valid_o, 0);
        chk("mid rst busy", busy_o, 0);
        chk("mid rst op_a", issue_op_a_o, 0);
        chk("mid rst instr", issue_instr_o, 0);
        chk("mid rst ready", instr_ready_o, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("mid rst release", instr_ready_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
